// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, ASCII constants for the optional display
// field, and a helper that sizes the decimal field for a given binary width.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Decimal digits needed to show 2^w-1, i.e. ceil(w*log10(2)).
  // Fixed-point log10(2) = 0.30103 is exact enough for any practical width.
  function automatic int digits_for_width(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Purely combinational; ports: din (4-bit digit in), dout (corrected digit).
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock).
// Latency: handshake in cycle T -> out_valid in cycle T+WIDTH+1; one result per WIDTH+2 cycles.
// Backpressure: in_ready is high only when idle; in_valid while busy is ignored, not queued.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_bits input handshake;
//   out_valid one-cycle result pulse; out_bcd/out_overflow held until next result;
//   out_ascii (only when BIN2BCD_ASCII_EN is defined) space-padded decimal text.
module bin_to_bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bits,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_overflow
`ifdef BIN2BCD_ASCII_EN
  ,
  output logic [8*DIGITS-1:0]   out_ascii
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  // When the digit field can hold 2^WIDTH-1 the overflow flag is constant 0.
  localparam bit OVF_POSSIBLE = (DIGITS < digits_for_width(WIDTH));

  state_t          state, state_next;
  logic            load, shift_en, last;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]   bcd, bcd_adj, bcd_shifted;
  logic            ovf, ovf_shifted;

  // Per-digit +3 correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (bcd[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign bcd_shifted = {bcd_adj[BW-2:0], shreg[WIDTH-1]};
  // A bit leaving the top kept digit means the dropped upper digits are
  // nonzero; the kept digits are unaffected since carries only move upward.
  assign ovf_shifted = OVF_POSSIBLE ? (ovf | bcd_adj[BW-1]) : 1'b0;
  assign last        = (cnt == CW'(1));

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result registers load on the final shift edge, so the DONE cycle shows
  // the new value together with out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      shreg        <= '0;
      bcd          <= '0;
      ovf          <= 1'b0;
      out_bcd      <= '0;
      out_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        shreg <= in_bits;
        bcd   <= '0;
        ovf   <= 1'b0;
        cnt   <= CW'(WIDTH);
      end else if (shift_en) begin
        shreg <= shreg << 1;
        bcd   <= bcd_shifted;
        ovf   <= ovf_shifted;
        cnt   <= cnt - CW'(1);
        if (last) begin
          out_bcd      <= bcd_shifted;
          out_overflow <= ovf_shifted;
        end
      end
    end
  end

`ifdef BIN2BCD_ASCII_EN
  logic [8*DIGITS-1:0] ascii_next;
  logic                leading;

  // Blank zero digits from the top down until the first nonzero digit;
  // the units digit always prints.
  always_comb begin
    ascii_next = '0;
    leading    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if ((bcd_shifted[4*k +: 4] != 4'd0) || (k == 0)) leading = 1'b0;
      ascii_next[8*k +: 8] = leading ? ASCII_SPACE
                                     : (ASCII_ZERO + {4'h0, bcd_shifted[4*k +: 4]});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ascii      <= {DIGITS{ASCII_SPACE}};
      out_ascii[7:0] <= ASCII_ZERO;
    end else if (shift_en && last) begin
      out_ascii <= ascii_next;
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: five parameterisations share one
// clock/reset and a selector; table vectors, hand sequences for back-to-back
// handshake and reset abort, then random values against a mod/div model.
module tb_bin_to_bcd_seq;

  localparam int WID [5] = '{16, 16, 8, 1, 20};
  localparam int DIG [5] = '{5, 4, 2, 1, 6};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] in_bits = '0;
  int          sel = 0;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic rdy0, rdy1, rdy2, rdy3, rdy4;
  logic vld0, vld1, vld2, vld3, vld4;
  logic ovf0, ovf1, ovf2, ovf3, ovf4;
  logic [19:0] bcd0;
  logic [15:0] bcd1;
  logic [7:0]  bcd2;
  logic [3:0]  bcd3;
  logic [23:0] bcd4;
`ifdef BIN2BCD_ASCII_EN
  logic [39:0] asc0;
  logic [31:0] asc1;
  logic [15:0] asc2;
  logic [7:0]  asc3;
  logic [47:0] asc4;
`endif

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 0)), .in_ready(rdy0),
    .in_bits(in_bits[15:0]), .out_valid(vld0), .out_bcd(bcd0), .out_overflow(ovf0)
`ifdef BIN2BCD_ASCII_EN
    , .out_ascii(asc0)
`endif
  );
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 1)), .in_ready(rdy1),
    .in_bits(in_bits[15:0]), .out_valid(vld1), .out_bcd(bcd1), .out_overflow(ovf1)
`ifdef BIN2BCD_ASCII_EN
    , .out_ascii(asc1)
`endif
  );
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2)), .in_ready(rdy2),
    .in_bits(in_bits[7:0]), .out_valid(vld2), .out_bcd(bcd2), .out_overflow(ovf2)
`ifdef BIN2BCD_ASCII_EN
    , .out_ascii(asc2)
`endif
  );
  bin_to_bcd_seq #(.WIDTH(1), .DIGITS(1)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 3)), .in_ready(rdy3),
    .in_bits(in_bits[0:0]), .out_valid(vld3), .out_bcd(bcd3), .out_overflow(ovf3)
`ifdef BIN2BCD_ASCII_EN
    , .out_ascii(asc3)
`endif
  );
  bin_to_bcd_seq #(.WIDTH(20), .DIGITS(6)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 4)), .in_ready(rdy4),
    .in_bits(in_bits), .out_valid(vld4), .out_bcd(bcd4), .out_overflow(ovf4)
`ifdef BIN2BCD_ASCII_EN
    , .out_ascii(asc4)
`endif
  );

  logic        m_rdy, m_vld, m_ovf;
  logic [23:0] m_bcd;
  always_comb begin
    m_rdy = rdy0; m_vld = vld0; m_ovf = ovf0; m_bcd = {4'h0, bcd0};
    case (sel)
      1: begin m_rdy = rdy1; m_vld = vld1; m_ovf = ovf1; m_bcd = {8'h0, bcd1}; end
      2: begin m_rdy = rdy2; m_vld = vld2; m_ovf = ovf2; m_bcd = {16'h0, bcd2}; end
      3: begin m_rdy = rdy3; m_vld = vld3; m_ovf = ovf3; m_bcd = {20'h0, bcd3}; end
      4: begin m_rdy = rdy4; m_vld = vld4; m_ovf = ovf4; m_bcd = bcd4; end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: low DIG digits of v by repeated mod/div; bit 24 = overflow.
  function automatic logic [24:0] model(input int s, input logic [19:0] v);
    int x;
    logic [23:0] b;
    x = int'(v);
    b = '0;
    for (int d = 0; d < DIG[s]; d++) begin
      b[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {(x != 0), b};
  endfunction

`ifdef BIN2BCD_ASCII_EN
  function automatic logic [39:0] asc_model(input logic [19:0] v);
    int x, nd;
    logic [39:0] a;
    x  = int'(v) % 100000;
    nd = 1;
    for (int t = x / 10; t != 0; t = t / 10) nd++;
    for (int d = 0; d < 5; d++) begin
      a[8*d +: 8] = (d < nd) ? 8'(48 + x % 10) : 8'h20;
      x = x / 10;
    end
    return a;
  endfunction
`endif

  // One full conversion on instance s; entered and left at a negedge.
  task automatic run_vec(input int s, input logic [19:0] v, input logic [23:0] eb,
                         input logic eo, input string nm);
    int k;
    sel = s;
    #1;
    k = 0;
    while (!m_rdy && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_ready"}, 64'(m_rdy), 64'd1);
    in_bits  = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!m_vld && k < 2 * WID[s] + 10) begin @(negedge clk); k++; end
    chk({nm, "_latency"}, 64'(k), 64'(WID[s] + 1));
    chk({nm, "_bcd"}, 64'(m_bcd), 64'(eb));
    chk({nm, "_ovf"}, 64'(m_ovf), 64'(eo));
`ifdef BIN2BCD_ASCII_EN
    if (s == 0) chk({nm, "_ascii"}, 64'(asc0), 64'(asc_model(v)));
`endif
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(m_vld), 64'd0);
  endtask

  typedef struct {
    int          s;
    logic [19:0] v;
    logic [23:0] bcd;
    logic        ovf;
  } vec_t;
  vec_t tab [17];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, cyc;
    logic drop, seen;
    logic [24:0] r;
    logic [19:0] v;

    tab[0]  = '{0, 20'd65535,   24'h065535, 1'b0};
    tab[1]  = '{0, 20'd0,       24'h000000, 1'b0};
    tab[2]  = '{0, 20'd1234,    24'h001234, 1'b0};
    tab[3]  = '{0, 20'd40000,   24'h040000, 1'b0};
    tab[4]  = '{0, 20'd10000,   24'h010000, 1'b0};
    tab[5]  = '{0, 20'd9,       24'h000009, 1'b0};
    tab[6]  = '{1, 20'd12345,   24'h002345, 1'b1};
    tab[7]  = '{1, 20'd9999,    24'h009999, 1'b0};
    tab[8]  = '{1, 20'd10000,   24'h000000, 1'b1};
    tab[9]  = '{1, 20'd65535,   24'h005535, 1'b1};
    tab[10] = '{2, 20'd255,     24'h000055, 1'b1};
    tab[11] = '{2, 20'd99,      24'h000099, 1'b0};
    tab[12] = '{2, 20'd100,     24'h000000, 1'b1};
    tab[13] = '{3, 20'd1,       24'h000001, 1'b0};
    tab[14] = '{3, 20'd0,       24'h000000, 1'b0};
    tab[15] = '{4, 20'd1048575, 24'h048575, 1'b1};
    tab[16] = '{4, 20'd999999,  24'h999999, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(rdy0), 64'd0);
    chk("rst_valid", 64'(vld0), 64'd0);
    chk("rst_bcd",   64'(bcd0), 64'd0);
    chk("rst_ovf",   64'(ovf0), 64'd0);
`ifdef BIN2BCD_ASCII_EN
    chk("rst_ascii", 64'(asc0), 64'h2020202030);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(rdy0), 64'd1);

    for (int i = 0; i < 17; i++)
      run_vec(tab[i].s, tab[i].v, tab[i].bcd, tab[i].ovf, $sformatf("tab%0d", i));

    // in_valid held high across two conversions: second accepted only when idle
    sel = 0;
    in_bits = 20'd1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_bits = 20'd40000;
    t1 = -1; t2 = -1; drop = 1'b0;
    for (cyc = 1; cyc < 80 && t2 < 0; cyc++) begin
      if (vld0) begin
        if (t1 < 0) begin t1 = cyc; chk("b2b_first_bcd", 64'(bcd0), 64'h01234); end
        else begin t2 = cyc; chk("b2b_second_bcd", 64'(bcd0), 64'h40000); end
      end
      if (drop) begin in_valid = 1'b0; drop = 1'b0; end
      if (rdy0 && in_valid) drop = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_first_latency", 64'(t1), 64'd17);
    chk("b2b_spacing", 64'(t2 - t1), 64'd18);
    repeat (5) @(negedge clk);
    chk("held_bcd", 64'(bcd0), 64'h40000);
    chk("held_valid", 64'(vld0), 64'd0);

    // Reset in the middle of a conversion aborts it
    sel = 0;
    in_bits = 20'hFFFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", 64'(rdy0), 64'd0);
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen = seen | vld0; end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 64'(rdy0), 64'd1);
    for (int i = 0; i < 30; i++) begin seen = seen | vld0; @(negedge clk); end
    chk("abort_no_valid", 64'(seen), 64'd0);
    chk("abort_bcd", 64'(bcd0), 64'd0);
    chk("abort_ovf", 64'(ovf0), 64'd0);

    // Random values on every parameterisation
    for (int s = 0; s < 5; s++) begin
      for (int n = 0; n < 400; n++) begin
        v = 20'($urandom) & 20'((1 << WID[s]) - 1);
        r = model(s, v);
        run_vec(s, v, r[23:0], r[24], $sformatf("rnd_s%0d_v%0d", s, v));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
